gravity_timer: RTL and testbench

Parametrised gravity and blink timing engine for the Tetris datapath. It tracks cleared lines and derives a saturating level. From the level it computes the gravity period and emits single-cycle gravity ticks to the piece FSM. It adds soft-drop acceleration, pause, a level-up pulse and an independent blink clock.

---
 rtl/tetris_timing_pkg.sv | 24 ++
 rtl/gravity_period_calc.sv | 50 +++++
 rtl/gravity_timer.sv | 159 +++++++++++++++
 tb/tb_gravity_timer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_timing_pkg.sv
// tetris_timing_pkg: shared timing defaults and line-accounting constants.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package tetris_timing_pkg;

  localparam int DEF_BASE_TICKS      = 25_000_000;
  localparam int DEF_STEP_TICKS      = 2_500_000;
  localparam int DEF_MIN_TICKS       = 2_500_000;
  localparam int DEF_SOFT_SHIFT      = 3;
  localparam int DEF_NUM_LEVELS      = 8;
  localparam int DEF_LINES_PER_LEVEL = 10;
  localparam int DEF_BLINK_TICKS     = 12_500_000;
  localparam int DEF_CNT_W           = 26;

  localparam int MAX_CLEAR = 4;
  localparam int LINES_W   = 10;
  localparam int LINES_MAX = (1 << LINES_W) - 1;

  // A single clear never removes more than four rows; larger counts are clipped.
  function automatic logic [2:0] clamp_clear(input logic [2:0] cnt);
    return (cnt > 3'(MAX_CLEAR)) ? 3'(MAX_CLEAR) : cnt;
  endfunction

endpackage

// File: rtl/gravity_period_calc.sv
// gravity_period_calc: level -> gravity period (BASE - level*STEP, floored at MIN).
// Latency: period_r follows level one clock later; clear forces BASE next clock.
// Backpressure: none.
module gravity_period_calc
  import tetris_timing_pkg::*;
#(
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int STEP_TICKS = DEF_STEP_TICKS,
  parameter int MIN_TICKS  = DEF_MIN_TICKS,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LVL_W      = 3
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             clear,
  input  logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] period_r
);

  // Four guard bits so level*STEP cannot wrap before the underflow test.
  localparam int CW = CNT_W + 4;
  localparam logic [CW-1:0] BASE_W = CW'(BASE_TICKS);
  localparam logic [CW-1:0] STEP_W = CW'(STEP_TICKS);
  localparam logic [CW-1:0] MIN_W  = CW'(MIN_TICKS);

  logic [CW-1:0] prod;
  logic [CW-1:0] diff;
  logic [CW-1:0] lvl_period;
  logic          under;

  // Level-derived period: an underflowing or too-short result clamps to the floor.
  always_comb begin
    prod       = CW'(level) * STEP_W;
    under      = (prod > BASE_W);
    diff       = BASE_W - prod;
    lvl_period = (under || (diff < MIN_W)) ? MIN_W : diff;
  end

  // Register the period; a restart snaps straight back to the level-0 period.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      period_r <= CNT_W'(BASE_TICKS);
    end else if (clear) begin
      period_r <= CNT_W'(BASE_TICKS);
    end else begin
      period_r <= lvl_period[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/gravity_timer.sv
// gravity_timer: gravity ticks, blink clock, line/level accounting; soft drop under SOFT_DROP_EN.
// Latency: tick_gravity, level_up and blink are registered; period tracks level one clock later.
// Backpressure: none; pause freezes gravity/blink counters, line clears are always accepted.
module gravity_timer
  import tetris_timing_pkg::*;
#(
  parameter int BASE_TICKS      = DEF_BASE_TICKS,
  parameter int STEP_TICKS      = DEF_STEP_TICKS,
  parameter int MIN_TICKS       = DEF_MIN_TICKS,
  parameter int SOFT_SHIFT      = DEF_SOFT_SHIFT,
  parameter int NUM_LEVELS      = DEF_NUM_LEVELS,
  parameter int LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
  parameter int BLINK_TICKS     = DEF_BLINK_TICKS,
  parameter int CNT_W           = DEF_CNT_W,
  localparam int LVL_W          = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               game_start,
  input  logic               pause,
  input  logic               soft_drop,
  input  logic               clear_valid,
  input  logic [2:0]         clear_count,
  output logic               tick_gravity,
  output logic               blink,
  output logic [LVL_W-1:0]   level,
  output logic               level_up,
  output logic [LINES_W-1:0] lines_total
);

  localparam int TW = LINES_W + 1;
  localparam logic [LINES_W-1:0] LPL_W      = LINES_W'(LINES_PER_LEVEL);
  localparam logic [LVL_W-1:0]   LVL_TOP    = LVL_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_TICKS - 1);

  logic [CNT_W-1:0]   period_r;
  logic [CNT_W-1:0]   eff;
  logic [CNT_W-1:0]   eff_last;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   blink_cnt;
  logic [LINES_W-1:0] lines_in_level;
  logic [2:0]         n;
  logic [TW-1:0]      total_sum;
  logic [LINES_W-1:0] total_nxt;
  logic [LINES_W-1:0] acc;
  logic [LINES_W-1:0] lil_nxt;
  logic               lvl_wrap;

  gravity_period_calc #(
    .BASE_TICKS (BASE_TICKS),
    .STEP_TICKS (STEP_TICKS),
    .MIN_TICKS  (MIN_TICKS),
    .CNT_W      (CNT_W),
    .LVL_W      (LVL_W)
  ) u_period (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .clear    (game_start),
    .level    (level),
    .period_r (period_r)
  );

`ifdef SOFT_DROP_EN
  logic [CNT_W-1:0] soft_p;

  // Soft drop shortens the period, never below two clocks.
  always_comb begin
    soft_p   = period_r >> SOFT_SHIFT;
    eff      = period_r;
    if (soft_drop) begin
      eff = (soft_p < CNT_W'(2)) ? CNT_W'(2) : soft_p;
    end
    eff_last = eff - CNT_W'(1);
  end
`else
  // Soft drop disabled: the port stays for interface stability but is ignored.
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop;

  // Effective period is the level period.
  always_comb begin
    eff      = period_r;
    eff_last = eff - CNT_W'(1);
  end
`endif

  // Gravity counter; >= lets a freshly shortened period fire at once.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt          <= '0;
      tick_gravity <= 1'b0;
    end else if (game_start) begin
      cnt          <= '0;
      tick_gravity <= 1'b0;
    end else if (pause) begin
      tick_gravity <= 1'b0;
    end else if (cnt >= eff_last) begin
      cnt          <= '0;
      tick_gravity <= 1'b1;
    end else begin
      cnt          <= cnt + CNT_W'(1);
      tick_gravity <= 1'b0;
    end
  end

  // Free-running blink clock, independent of gravity, frozen while paused.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (game_start) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else if (!pause) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // Next line totals and in-level progress for the current clear event.
  always_comb begin
    n         = clamp_clear(clear_count);
    total_sum = TW'(lines_total) + TW'(n);
    total_nxt = (total_sum > TW'(LINES_MAX)) ? LINES_W'(LINES_MAX) : total_sum[LINES_W-1:0];
    acc       = lines_in_level + LINES_W'(n);
    lvl_wrap  = (acc >= LPL_W);
    lil_nxt   = lvl_wrap ? (acc - LPL_W) : acc;
  end

  // Line accounting and level advance; restart wins over a same-cycle clear.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      lines_total    <= '0;
      lines_in_level <= '0;
      level          <= '0;
      level_up       <= 1'b0;
    end else if (game_start) begin
      lines_total    <= '0;
      lines_in_level <= '0;
      level          <= '0;
      level_up       <= 1'b0;
    end else begin
      level_up <= 1'b0;
      if (clear_valid && (n != 3'd0)) begin
        lines_total    <= total_nxt;
        lines_in_level <= lil_nxt;
        if (lvl_wrap && (level != LVL_TOP)) begin
          level    <= level + LVL_W'(1);
          level_up <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gravity_timer.sv
// tb_gravity_timer: directed sequences, a line-accounting table and random traffic vs a reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_gravity_timer;

  localparam int BASE = 20;
  localparam int STEP = 4;
  localparam int MINP = 8;
  localparam int SSH  = 1;
  localparam int NL   = 4;
  localparam int LPL  = 5;
  localparam int BLK  = 5;
  localparam int CW   = 8;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       game_start = 1'b0;
  logic       pause = 1'b0;
  logic       soft_drop = 1'b0;
  logic       clear_valid = 1'b0;
  logic [2:0] clear_count = 3'd0;
  logic       tick_gravity;
  logic       blink;
  logic [1:0] level;
  logic       level_up;
  logic [9:0] lines_total;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, expressed as plain integers
  int m_cnt, m_bcnt, m_level, m_lil, m_total, m_period;
  bit m_tick, m_blink, m_lu;

  typedef struct {
    bit cv;
    int cc;
    bit pz;
    bit lu;
    int lvl;
    int tot;
  } vec_t;
  vec_t tbl[8];

  gravity_timer #(
    .BASE_TICKS      (BASE),
    .STEP_TICKS      (STEP),
    .MIN_TICKS       (MINP),
    .SOFT_SHIFT      (SSH),
    .NUM_LEVELS      (NL),
    .LINES_PER_LEVEL (LPL),
    .BLINK_TICKS     (BLK),
    .CNT_W           (CW)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .game_start   (game_start),
    .pause        (pause),
    .soft_drop    (soft_drop),
    .clear_valid  (clear_valid),
    .clear_count  (clear_count),
    .tick_gravity (tick_gravity),
    .blink        (blink),
    .level        (level),
    .level_up     (level_up),
    .lines_total  (lines_total)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lvl_period(input int lv);
    int p;
    p = BASE - lv * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_bcnt = 0; m_level = 0; m_lil = 0; m_total = 0;
    m_period = BASE; m_tick = 0; m_blink = 0; m_lu = 0;
  endtask

  // One clock of game rules, applied to the inputs the DUT sampled on this edge
  task automatic model_step();
    int eff, nn, acc;
    if (!resetn || game_start) begin
      model_reset();
    end else begin
      eff = m_period;
`ifdef SOFT_DROP_EN
      if (soft_drop) eff = ((m_period >> SSH) < 2) ? 2 : (m_period >> SSH);
`endif
      m_period = lvl_period(m_level);
      if (!pause) begin
        if (m_cnt >= eff - 1) begin m_cnt = 0; m_tick = 1; end
        else begin m_cnt++; m_tick = 0; end
        if (m_bcnt == BLK - 1) begin m_bcnt = 0; m_blink = !m_blink; end
        else m_bcnt++;
      end else begin
        m_tick = 0;
      end
      m_lu = 0;
      nn = (int'(clear_count) > 4) ? 4 : int'(clear_count);
      if (clear_valid && nn > 0) begin
        m_total = (m_total + nn > 1023) ? 1023 : m_total + nn;
        acc = m_lil + nn;
        if (acc >= LPL) begin
          m_lil = acc - LPL;
          if (m_level < NL - 1) begin m_level++; m_lu = 1; end
        end else begin
          m_lil = acc;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    model_step();
    #1;
    check("tick", tick_gravity, m_tick);
    check("blink", blink, m_blink);
    check("level", level, m_level);
    check("level_up", level_up, m_lu);
    check("lines_total", lines_total, m_total);
  endtask

  task automatic wait_tick(input string name, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!tick_gravity && cycles < 200);
    if (!tick_gravity) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no tick within 200 clocks", name);
    end
  endtask

  task automatic do_clear(input int cc);
    clear_valid = 1'b1;
    clear_count = 3'(cc);
    cyc();
    clear_valid = 1'b0;
    clear_count = 3'd0;
  endtask

  task automatic restart();
    game_start = 1'b1;
    cyc();
    game_start = 1'b0;
  endtask

  initial begin
    int c, ticks;
    logic b0;

    // rows: clear_valid, count, pause, expected level_up, level, lines_total
    tbl[0] = '{1, 4, 0, 1, 2, 10};
    tbl[1] = '{1, 4, 1, 0, 2, 14};
    tbl[2] = '{1, 4, 1, 1, 3, 18};
    tbl[3] = '{1, 4, 0, 0, 3, 22};
    tbl[4] = '{1, 4, 0, 0, 3, 26};
    tbl[5] = '{1, 7, 1, 0, 3, 30};
    tbl[6] = '{1, 0, 0, 0, 3, 30};
    tbl[7] = '{0, 4, 0, 0, 3, 30};

    model_reset();
    repeat (2) cyc();
    check("reset_tick", tick_gravity, 0);
    check("reset_level", level, 0);
    check("reset_lines", lines_total, 0);
    resetn = 1'b1;

    // Idle: ticks every 20 clocks from reset release, blink every 5
    wait_tick("t1_first", c);  check("t1_first_gap", c, 20);
    check("t1_level", level, 0);
    wait_tick("t1_second", c); check("t1_second_gap", c, 20);
    wait_tick("t1_third", c);  check("t1_third_gap", c, 20);
    b0 = blink;
    repeat (4) cyc();
    check("t1_blink_hold", blink, b0);
    cyc();
    check("t1_blink_toggle", blink, !b0);

    // Two clears of 3 cross into level 1
    do_clear(3);
    check("t2_no_lu", level_up, 0);
    clear_valid = 1'b1; clear_count = 3'd3;
    cyc();
    clear_valid = 1'b0; clear_count = 3'd0;
    check("t2_level_up", level_up, 1);
    check("t2_level", level, 1);
    check("t2_lines", lines_total, 6);
    cyc();
    check("t2_lu_pulse", level_up, 0);
    wait_tick("t2_tick_a", c);
    wait_tick("t2_tick_b", c);
    check("t2_period16", c, 16);

    // Line accounting table; the first row also proves one line carried over
    for (int i = 0; i < 8; i++) begin
      clear_valid = tbl[i].cv;
      clear_count = 3'(tbl[i].cc);
      pause = tbl[i].pz;
      cyc();
      check($sformatf("t3_row%0d_lu", i), level_up, tbl[i].lu);
      check($sformatf("t3_row%0d_level", i), level, tbl[i].lvl);
      check($sformatf("t3_row%0d_lines", i), lines_total, tbl[i].tot);
    end
    clear_valid = 1'b0; clear_count = 3'd0; pause = 1'b0;
    wait_tick("t3_tick_a", c);
    wait_tick("t3_tick_b", c);
    check("t3_period8", c, 8);

    // Pause with 10 of 20 clocks consumed: the remaining 10 run after release
    restart();
    wait_tick("t4_restart", c); check("t4_restart_gap", c, 20);
    repeat (10) cyc();
    pause = 1'b1;
    b0 = blink;
    ticks = 0;
    repeat (50) begin
      cyc();
      ticks += int'(tick_gravity);
    end
    check("t4_pause_ticks", ticks, 0);
    check("t4_blink_frozen", blink, b0);
    pause = 1'b0;
    wait_tick("t4_resume", c); check("t4_resume_gap", c, BASE - 10);

    // Soft drop raised with 15 clocks consumed
    restart();
    wait_tick("t5_start", c);
    repeat (15) cyc();
    soft_drop = 1'b1;
    wait_tick("t5_first", c);
`ifdef SOFT_DROP_EN
    check("t5_first_gap", c, 1);
    wait_tick("t5_next", c); check("t5_soft_gap", c, 10);
`else
    check("t5_first_gap", c, 5);
    wait_tick("t5_next", c); check("t5_soft_gap", c, 20);
`endif
    soft_drop = 1'b0;

    // Restart at level 2 with a simultaneous clear of 4
    restart();
    do_clear(4); do_clear(1); do_clear(4); do_clear(1);
    check("t6_level2", level, 2);
    game_start = 1'b1; clear_valid = 1'b1; clear_count = 3'd4;
    cyc();
    game_start = 1'b0; clear_valid = 1'b0; clear_count = 3'd0;
    check("t6_level", level, 0);
    check("t6_lines", lines_total, 0);
    check("t6_no_lu", level_up, 0);
    wait_tick("t6_tick", c); check("t6_first_gap", c, 20);

    // lines_total saturates at 1023
    clear_valid = 1'b1; clear_count = 3'd4;
    repeat (256) cyc();
    clear_valid = 1'b0; clear_count = 3'd0;
    check("sat_lines", lines_total, 1023);
    check("sat_level", level, 3);

    // Asynchronous reset mid-count clears everything at once
    repeat (7) cyc();
    #2;
    resetn = 1'b0;
    #1;
    check("arst_tick", tick_gravity, 0);
    check("arst_blink", blink, 0);
    check("arst_level", level, 0);
    check("arst_lines", lines_total, 0);
    model_reset();
    cyc();
    resetn = 1'b1;
    wait_tick("arst_tick_after", c); check("arst_first_gap", c, 20);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      game_start  = ($urandom_range(0, 199) == 0);
      pause       = ($urandom_range(0, 4) == 0);
      soft_drop   = ($urandom_range(0, 3) == 0);
      clear_valid = ($urandom_range(0, 5) == 0);
      clear_count = 3'($urandom_range(0, 7));
      cyc();
    end
    game_start = 1'b0; pause = 1'b0; soft_drop = 1'b0; clear_valid = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
